hawk_axiwr_arb: RTL and testbench

- Shares the single hawk_axiwr_master write port among NUM_REQ write-issuing managers, e.g. page-write manager, ToL update engine and zspage migrate engine.
- Uses round-robin arbitration with one AXI write outstanding at a time.
- Latches the winner's payload (axi_wr_pld_t), drives AW and W handshakes independently, waits for B, and returns bresp to the owning requester.
- Sits between the managers and hawk_axiwr_master inside the hacd block.

---
 rtl/hacd_pkg.sv | 53 +++++
 rtl/hawk_rr_arb.sv | 37 +++
 rtl/hawk_axiwr_arb.sv | 132 +++++++++++++
 tb/tb_hawk_axiwr_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared hacd types: AXI write payload/handshake packets, write-arbiter FSM state, helpers.
package hacd_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 512;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } axi_wr_pld_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  awvalid;
    logic                  wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic [1:0] bresp;
    logic       bvalid;
  } axi_wr_resppkt_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_B
  } wr_arb_state_t;

  // Ceiling log2, never less than 1 so a 2-entry index still has a bit.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hawk_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module hawk_rr_arb
  import hacd_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = clogb2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      jj = IDX_W'(j);
      if (!vld_o && req_i[jj]) begin
        vld_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter sharing one AXI write port among NUM_REQ managers,
// one write outstanding; bresp routed back to the owning requester.
module hawk_axiwr_arb
  import hacd_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic            [NUM_REQ-1:0] req_valid_i,
  input  axi_wr_pld_t     [NUM_REQ-1:0] req_pld_i,
  output logic            [NUM_REQ-1:0] req_ready_o,
  output logic            [NUM_REQ-1:0] resp_valid_o,
  output logic            [1:0]         resp_bresp_o,
  output axi_wr_reqpkt_t                wr_reqpkt_o,
  input  axi_wr_rdypkt_t                wr_rdypkt_i,
  input  axi_wr_resppkt_t               wr_resppkt_i,
  output logic                          bready_o,
  output logic                          busy_o,
  output logic            [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned IDX_W = clogb2(NUM_REQ);

  wr_arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  axi_wr_pld_t          pld_q, pld_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 awvalid, wvalid;
  logic                 aw_hit, w_hit;

  hawk_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      pld_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      pld_q     <= pld_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    pld_d        = pld_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    err_cnt_d    = err_cnt_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_bresp_o = '0;
    bready_o     = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    aw_hit       = 1'b0;
    w_hit        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          // Ready is gated by reset so a held request sees nothing while in reset.
          req_ready_o = gnt & {NUM_REQ{rst_ni}};
          pld_d       = req_pld_i[gnt_idx];
          owner_d     = gnt_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_hit  = aw_done_q | wr_rdypkt_i.awready;
        w_hit   = w_done_q | wr_rdypkt_i.wready;
        if (aw_hit && w_hit) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WAIT_B;
        end else begin
          aw_done_d = aw_hit;
          w_done_d  = w_hit;
        end
      end
      WAIT_B: begin
        bready_o = 1'b1;
        if (wr_resppkt_i.bvalid) begin
          resp_valid_o[owner_q] = 1'b1;
          resp_bresp_o          = wr_resppkt_i.bresp;
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          if (wr_resppkt_i.bresp != AXI_RESP_OKAY && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_reqpkt_o.addr    = pld_q.addr;
  assign wr_reqpkt_o.data    = pld_q.data;
  assign wr_reqpkt_o.strb    = pld_q.strb;
  assign wr_reqpkt_o.awvalid = awvalid;
  assign wr_reqpkt_o.wvalid  = wvalid;
  assign busy_o              = (state_q != IDLE);
  assign err_cnt_o           = err_cnt_q;

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Directed bench for hawk_axiwr_arb with a response scoreboard and a cycle-driven slave.
module tb_hawk_axiwr_arb;
  import hacd_pkg::*;

  localparam int unsigned N = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid_i;
  axi_wr_pld_t [N-1:0]   pld;
  logic [N-1:0]          req_ready_o;
  logic [N-1:0]          resp_valid_o;
  logic [1:0]            resp_bresp_o;
  axi_wr_reqpkt_t        wr_reqpkt_o;
  axi_wr_rdypkt_t        wr_rdypkt_i;
  axi_wr_resppkt_t       wr_resppkt_i;
  logic                  bready_o;
  logic                  busy_o;
  logic [7:0]            err_cnt_o;

  int checks = 0;
  int errors = 0;
  int err_model = 0;
  int cur_idx = 0;
  logic [N-1:0] vld_hold;

  typedef struct packed {
    logic [1:0] owner;
    logic [1:0] bresp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  hawk_axiwr_arb #(.NUM_REQ(N), .ERR_CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid_i),
    .req_pld_i    (pld),
    .req_ready_o  (req_ready_o),
    .resp_valid_o (resp_valid_o),
    .resp_bresp_o (resp_bresp_o),
    .wr_reqpkt_o  (wr_reqpkt_o),
    .wr_rdypkt_i  (wr_rdypkt_i),
    .wr_resppkt_i (wr_resppkt_i),
    .bready_o     (bready_o),
    .busy_o       (busy_o),
    .err_cnt_o    (err_cnt_o)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic aw, input logic w, input logic bv, input logic [1:0] br);
    wr_rdypkt_i.awready = aw;
    wr_rdypkt_i.wready  = w;
    wr_resppkt_i.bvalid = bv;
    wr_resppkt_i.bresp  = br;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ready"}, 512'(req_ready_o), 512'(0));
    check({tag, "_resp"}, 512'(resp_valid_o), 512'(0));
    check({tag, "_bresp"}, 512'(resp_bresp_o), 512'(0));
    check({tag, "_addr"}, 512'(wr_reqpkt_o.addr), 512'(0));
    check({tag, "_data"}, wr_reqpkt_o.data, 512'(0));
    check({tag, "_strb"}, 512'(wr_reqpkt_o.strb), 512'(0));
    check({tag, "_awvalid"}, 512'(wr_reqpkt_o.awvalid), 512'(0));
    check({tag, "_wvalid"}, 512'(wr_reqpkt_o.wvalid), 512'(0));
    check({tag, "_bready"}, 512'(bready_o), 512'(0));
    check({tag, "_busy"}, 512'(busy_o), 512'(0));
    check({tag, "_errcnt"}, 512'(err_cnt_o), 512'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = '1;
    drive(1'b1, 1'b1, 1'b1, 2'b10);
    #1;
    check_quiet_outputs("reset");
    repeat (2) @(negedge clk);
    #1;
    check_quiet_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = '0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    err_model = 0;
    sb_q.delete();
  endtask

  task automatic wait_grant(input logic [N-1:0] vld, input bit keep, input int gi, input logic [1:0] br);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      req_valid_i = vld;
      drive(1'b0, 1'b0, 1'b0, 2'b00);
      #1;
      check("idle_errcnt", 512'(err_cnt_o), 512'(err_model));
      check("idle_resp", 512'(resp_valid_o), 512'(0));
      check("idle_bready", 512'(bready_o), 512'(0));
      check("idle_busy", 512'(busy_o), 512'(0));
      if (|req_ready_o) got = 1'b1;
    end
    check("grant_timeout", 512'(got), 512'(1));
    check("grant", 512'(req_ready_o), 512'(N'(1) << gi));
    if (got) sb_q.push_back('{owner: 2'(gi), bresp: br});
    cur_idx  = gi;
    vld_hold = keep ? vld : (vld & ~(N'(1) << gi));
  endtask

  task automatic do_issue(input int aw_d, input int w_d, input bit early_b, input logic [1:0] br);
    bit aw_seen, w_seen;
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    for (int k = 0; k < 20 && !(aw_seen && w_seen); k++) begin
      @(negedge clk);
      req_valid_i = vld_hold;
      drive(k >= aw_d, k >= w_d, early_b, early_b ? br : 2'b00);
      #1;
      check("awvalid", 512'(wr_reqpkt_o.awvalid), 512'(!aw_seen));
      check("wvalid", 512'(wr_reqpkt_o.wvalid), 512'(!w_seen));
      check("addr", 512'(wr_reqpkt_o.addr), 512'(pld[cur_idx].addr));
      check("data", wr_reqpkt_o.data, pld[cur_idx].data);
      check("strb", 512'(wr_reqpkt_o.strb), 512'(pld[cur_idx].strb));
      check("issue_bready", 512'(bready_o), 512'(0));
      check("issue_resp", 512'(resp_valid_o), 512'(0));
      check("issue_ready", 512'(req_ready_o), 512'(0));
      check("issue_busy", 512'(busy_o), 512'(1));
      if (k >= aw_d) aw_seen = 1'b1;
      if (k >= w_d) w_seen = 1'b1;
    end
    check("issue_timeout", 512'(aw_seen && w_seen), 512'(1));
  endtask

  task automatic do_waitb(input int b_d, input logic [1:0] br);
    bit done;
    sb_t e;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      req_valid_i = vld_hold;
      drive(1'b0, 1'b0, k >= b_d, br);
      #1;
      check("waitb_bready", 512'(bready_o), 512'(1));
      check("waitb_busy", 512'(busy_o), 512'(1));
      check("waitb_ready", 512'(req_ready_o), 512'(0));
      if (k >= b_d) begin
        check("sb_depth", 512'(sb_q.size()), 512'(1));
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("resp_valid", 512'(resp_valid_o), 512'(N'(1) << e.owner));
          check("resp_bresp", 512'(resp_bresp_o), 512'(e.bresp));
          if (e.bresp != 2'b00 && err_model < 255) err_model++;
        end
        done = 1'b1;
      end else begin
        check("resp_early", 512'(resp_valid_o), 512'(0));
      end
    end
    check("waitb_timeout", 512'(done), 512'(1));
  endtask

  task automatic run_txn(input logic [N-1:0] vld, input bit keep, input int gi,
                         input int aw_d, input int w_d, input int b_d,
                         input bit early_b, input logic [1:0] br);
    wait_grant(vld, keep, gi, br);
    do_issue(aw_d, w_d, early_b, br);
    do_waitb(b_d, br);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req_valid_i = '0;
      drive(1'b0, 1'b0, 1'b0, 2'b00);
      #1;
      check("quiet_resp", 512'(resp_valid_o), 512'(0));
      check("quiet_ready", 512'(req_ready_o), 512'(0));
      check("quiet_busy", 512'(busy_o), 512'(0));
      check("quiet_errcnt", 512'(err_cnt_o), 512'(err_model));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = '0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    pld[0] = '{addr: 64'hFFF6200040, data: {64{8'hA5}}, strb: '1};
    pld[1] = '{addr: 64'h0000_0000_0000_1000, data: {16{32'hDEADBEEF}}, strb: {8{8'h0F}}};
    pld[2] = '{addr: 64'h0000_0000_2000_0040, data: {8{64'h0123456789ABCDEF}}, strb: {32{2'b01}}};
    vld_hold = '0;

    do_reset();

    // Single request, zero-wait slave
    run_txn(3'b001, 1'b0, 0, 0, 0, 0, 1'b0, 2'b00);
    idle_cycles(2);

    // All requesters held from reset: strict rotation
    do_reset();
    for (int t = 0; t < 6; t++) begin
      run_txn(3'b111, 1'b1, t % 3, 0, 0, 0, 1'b0, 2'b00);
    end

    // wready three cycles ahead of awready
    run_txn(3'b010, 1'b0, 1, 3, 0, 1, 1'b0, 2'b00);

    // AW ahead of W with delayed B
    run_txn(3'b100, 1'b0, 2, 0, 2, 2, 1'b0, 2'b00);

    // bvalid raised during ISSUE must wait for bready
    run_txn(3'b001, 1'b0, 0, 1, 1, 0, 1'b1, 2'b01);
    idle_cycles(3);

    // Error responses saturate the counter
    for (int t = 0; t < 300; t++) begin
      run_txn(3'b010, 1'b1, 1, 0, 0, 0, 1'b0, 2'b10);
    end
    idle_cycles(2);
    check("err_sat", 512'(err_cnt_o), 512'(255));

    // Reset while waiting for B
    wait_grant(3'b100, 1'b0, 2, 2'b00);
    do_issue(0, 0, 1'b0, 2'b00);
    @(negedge clk);
    req_valid_i = '0;
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    check("pre_rst_bready", 512'(bready_o), 512'(1));
    check("pre_rst_resp", 512'(resp_valid_o), 512'(0));
    do_reset();
    run_txn(3'b111, 1'b0, 0, 0, 0, 0, 1'b0, 2'b00);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
